// File: rtl/exc_unit_n.sv
// ---------------------------------------------------------------------------
// exc_unit_n -- parametrised exception / interrupt sequencing unit.
//
// Purpose:
//   Collects NCAUSE cause lines into a sticky pending register and masks them
//   with SR. The lowest NMI indices are non-maskable. A pending, unmasked
//   cause starts an entry handshake: jisr is raised and held until the
//   pipeline acks. On the ack clock the context (SR, mode, cause set, PCs,
//   effective address) is saved into SPRs. eret restores SR and mode.
//
// Optional feature:
//   Define EXC_COUNT_EN to add a W-bit entry counter, readable at reg_sel 7.
//   Any SPR write to reg_sel 7 clears it. Without the macro, reg_sel 7 reads
//   0 and writes to it are ignored.
//
// Ports:
//   clk, rst         system clock, asynchronous active-high reset
//   ca[NCAUSE]       cause inputs, sampled every clock
//   ack              pipeline accepted the ISR jump this cycle
//   eret             return-from-exception pulse (acted on only in ISR)
//   rpt              EPC selects pc (repeat) instead of next_pc
//   pc, next_pc, ea  current/next instruction address, load/store address
//   sprw, reg_sel,   SPR write strobe, SPR select, SPR write data
//   data_in
//   spr_out          SPR read data (combinational on reg_sel)
//   jisr             registered exception request to the pipeline
//   isr_pc           constant ISR start address SISR
//   eret_pc          EPC
//   mca              masked pending causes
//   il               index of the lowest set bit of mca (0 when none)
//   mode             0 = system, 1 = user
// ---------------------------------------------------------------------------
module exc_unit_n #(
    parameter int             NCAUSE = 23,
    parameter int             NMI    = 1,
    parameter int             W      = 32,
    parameter logic [W-1:0]   SISR   = '0,
    parameter int             ILW    = $clog2(NCAUSE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCAUSE-1:0] ca,
    input  logic              ack,
    input  logic              eret,
    input  logic              rpt,
    input  logic [W-1:0]      pc,
    input  logic [W-1:0]      next_pc,
    input  logic [W-1:0]      ea,
    input  logic              sprw,
    input  logic [2:0]        reg_sel,
    input  logic [W-1:0]      data_in,
    output logic [W-1:0]      spr_out,
    output logic              jisr,
    output logic [W-1:0]      isr_pc,
    output logic [W-1:0]      eret_pc,
    output logic [NCAUSE-1:0] mca,
    output logic [ILW-1:0]    il,
    output logic              mode
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_ISR   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q,  state_d;
    logic                jisr_q,   jisr_d;
    logic [NCAUSE-1:0]   pend_q,   pend_d;
    logic [W-1:0]        sr_q,     sr_d;
    logic [W-1:0]        esr_q,    esr_d;
    logic [NCAUSE-1:0]   eca_q,    eca_d;
    logic [W-1:0]        epc_q,    epc_d;
    logic [W-1:0]        edpc_q,   edpc_d;
    logic [W-1:0]        edata_q,  edata_d;
    logic                mode_q,   mode_d;
    logic                emode_q,  emode_d;
`ifdef EXC_COUNT_EN
    logic [W-1:0]        cnt_q,    cnt_d;
`endif

    // ------------------------------------------------------------------
    // Masking: NMI lines ignore SR, the rest are gated by their SR bit.
    // ------------------------------------------------------------------
    logic [NCAUSE-1:0] mask;
    logic [NCAUSE-1:0] mca_c;

    generate
        for (genvar gi = 0; gi < NCAUSE; gi++) begin : g_mask
            if (gi < NMI) begin : g_nmi
                assign mask[gi] = 1'b1;
            end else begin : g_maskable
                assign mask[gi] = sr_q[gi];
            end
        end
    endgenerate

    assign mca_c = pend_q & mask;

    // Entry save happens on the ack clock of ENTRY; restore on eret in ISR.
    logic save_c;
    logic restore_c;
    logic [NCAUSE-1:0] clr_c;

    assign save_c    = (state_q == ST_ENTRY) && ack;
    assign restore_c = (state_q == ST_ISR) && eret;
    assign clr_c     = save_c ? mca_c : '0;

    // ------------------------------------------------------------------
    // Lowest set bit of mca: scanning downward lets the lowest index win.
    // ------------------------------------------------------------------
    logic [ILW-1:0] il_c;

    always_comb begin
        il_c = '0;
        for (int i = NCAUSE - 1; i >= 0; i--) begin
            if (mca_c[i]) begin
                il_c = ILW'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending register. Captured bits are cleared first and new cause
    // inputs OR'd in afterwards, so a line that is high on the capture
    // clock is not lost.
    // ------------------------------------------------------------------
    always_comb begin
        pend_d = (pend_q & ~clr_c) | ca;
    end

    // ------------------------------------------------------------------
    // SPR next-state. Software writes are applied first; save/restore
    // then override only the registers they touch.
    // ------------------------------------------------------------------
    always_comb begin
        sr_d    = sr_q;
        esr_d   = esr_q;
        eca_d   = eca_q;
        epc_d   = epc_q;
        edpc_d  = edpc_q;
        edata_d = edata_q;
        mode_d  = mode_q;
        emode_d = emode_q;
`ifdef EXC_COUNT_EN
        cnt_d   = cnt_q;
`endif

        // An entry increments the counter. A software write to the counter
        // is applied below and overrides the increment.
`ifdef EXC_COUNT_EN
        if (save_c) begin
            cnt_d = cnt_q + 1'b1;
        end
`endif

        if (sprw) begin
            case (reg_sel)
                3'd0: sr_d    = data_in;
                3'd1: esr_d   = data_in;
                3'd2: eca_d   = data_in[NCAUSE-1:0];
                3'd3: epc_d   = data_in;
                3'd4: edpc_d  = data_in;
                3'd5: edata_d = data_in;
                3'd6: mode_d  = data_in[0];
`ifdef EXC_COUNT_EN
                3'd7: cnt_d   = '0;
`endif
                default: ;
            endcase
        end

        if (save_c) begin
            eca_d   = mca_c;
            esr_d   = sr_q;
            emode_d = mode_q;
            sr_d    = '0;
            mode_d  = 1'b0;
            epc_d   = rpt ? pc : next_pc;
            edpc_d  = pc;
            edata_d = ea;
        end

        if (restore_c) begin
            sr_d   = esr_q;
            mode_d = emode_q;
        end
    end

    // ------------------------------------------------------------------
    // Entry FSM next-state. jisr is registered alongside the state, so it
    // rises with the first ENTRY cycle and falls with the first ISR cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        jisr_d  = jisr_q;
        case (state_q)
            ST_IDLE: begin
                if (|mca_c) begin
                    state_d = ST_ENTRY;
                    jisr_d  = 1'b1;
                end
            end
            ST_ENTRY: begin
                if (ack) begin
                    state_d = ST_ISR;
                    jisr_d  = 1'b0;
                end
            end
            ST_ISR: begin
                // No nesting: causes only accumulate in pend until eret.
                if (eret) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                jisr_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            jisr_q  <= 1'b0;
            pend_q  <= '0;
            sr_q    <= '0;
            esr_q   <= '0;
            eca_q   <= '0;
            epc_q   <= '0;
            edpc_q  <= '0;
            edata_q <= '0;
            mode_q  <= 1'b0;
            emode_q <= 1'b0;
`ifdef EXC_COUNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            jisr_q  <= jisr_d;
            pend_q  <= pend_d;
            sr_q    <= sr_d;
            esr_q   <= esr_d;
            eca_q   <= eca_d;
            epc_q   <= epc_d;
            edpc_q  <= edpc_d;
            edata_q <= edata_d;
            mode_q  <= mode_d;
            emode_q <= emode_d;
`ifdef EXC_COUNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // SPR read mux
    // ------------------------------------------------------------------
    always_comb begin
        spr_out = '0;
        case (reg_sel)
            3'd0: spr_out = sr_q;
            3'd1: spr_out = esr_q;
            3'd2: spr_out[NCAUSE-1:0] = eca_q;
            3'd3: spr_out = epc_q;
            3'd4: spr_out = edpc_q;
            3'd5: spr_out = edata_q;
            3'd6: spr_out[0] = mode_q;
`ifdef EXC_COUNT_EN
            3'd7: spr_out = cnt_q;
`endif
            default: spr_out = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign jisr    = jisr_q;
    assign isr_pc  = SISR;
    assign eret_pc = epc_q;
    assign mca     = mca_c;
    assign il      = il_c;
    assign mode    = mode_q;

endmodule
